// File: rtl/rob_issue_alloc_if.sv
// Issue / CDB / commit bundle between the ROB allocation block and its neighbours.
// The slave modport is the ROB side; the master modport drives the pipeline side.
interface rob_issue_alloc_if #(
  parameter int unsigned ROB_DEPTH  = 4,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned REG_ADDR_W = 3
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [INSTR_W-1:0]    issue_instr;
  logic [REG_ADDR_W-1:0] issue_dest;
  logic [TAG_W-1:0]      issue_tag;
  logic [REG_ADDR_W-1:0] src_reg;
  logic                  src_busy;
  logic [TAG_W-1:0]      src_tag;
  logic                  cdb_valid;
  logic [TAG_W-1:0]      cdb_tag;
  logic [DATA_W-1:0]     cdb_value;
  logic                  head_valid;
  logic [TAG_W-1:0]      head_tag;
  logic [INSTR_W-1:0]    head_instr;
  logic [REG_ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0]     head_value;
  logic                  commit_ack;
  logic [TAG_W:0]        count;
  logic                  empty;
  logic                  full;

  modport slave (
    input  issue_valid, issue_instr, issue_dest, src_reg,
    input  cdb_valid, cdb_tag, cdb_value, commit_ack,
    output issue_ready, issue_tag, src_busy, src_tag,
    output head_valid, head_tag, head_instr, head_dest, head_value,
    output count, empty, full
  );

  modport master (
    output issue_valid, issue_instr, issue_dest, src_reg,
    output cdb_valid, cdb_tag, cdb_value, commit_ack,
    input  issue_ready, issue_tag, src_busy, src_tag,
    input  head_valid, head_tag, head_instr, head_dest, head_value,
    input  count, empty, full
  );
endinterface

// File: rtl/rob_issue_alloc.sv
// Reorder-buffer allocation/writeback: tail allocation, rename table, CDB capture,
// and head presentation to the commit stage.
module rob_issue_alloc #(
  parameter int unsigned ROB_DEPTH  = 4,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input logic              clk,
  input logic              rst_n,
  rob_issue_alloc_if.slave rob
);
  localparam int unsigned   NumRegs  = 2 ** REG_ADDR_W;
  localparam logic [TAG_W:0] DepthCnt = (TAG_W + 1)'(ROB_DEPTH);

  logic [TAG_W-1:0]      r_head;
  logic [TAG_W-1:0]      r_tail;
  logic [TAG_W:0]        r_count;
  logic [ROB_DEPTH-1:0]  r_alloc;
  logic [ROB_DEPTH-1:0]  r_ready;
  logic [INSTR_W-1:0]    r_instr [ROB_DEPTH];
  logic [REG_ADDR_W-1:0] r_dest  [ROB_DEPTH];
  logic [DATA_W-1:0]     r_value [ROB_DEPTH];
  logic [NumRegs-1:0]    r_busy;
  logic [TAG_W-1:0]      r_rtag  [NumRegs];

  logic                  w_full;
  logic                  w_head_valid;
  logic                  w_alloc;
  logic                  w_commit;
  logic                  w_cdb;
  logic                  w_rename_clr;
  logic [REG_ADDR_W-1:0] w_head_dest;
  logic [TAG_W:0]        w_count_d;

  assign w_full       = (r_count == DepthCnt);
  assign w_head_valid = r_alloc[r_head] && r_ready[r_head];
  assign w_head_dest  = r_dest[r_head];
  assign w_alloc      = rob.issue_valid && !w_full;
  assign w_commit     = rob.commit_ack && w_head_valid;

  // Allocation of the same slot takes precedence over a stray broadcast to it.
  assign w_cdb = rob.cdb_valid && r_alloc[rob.cdb_tag] && !r_ready[rob.cdb_tag] &&
                 !(w_alloc && (rob.cdb_tag == r_tail));

  // Only the most recent producer may release the rename entry.
  assign w_rename_clr = w_commit && r_busy[w_head_dest] && (r_rtag[w_head_dest] == r_head);

  assign rob.issue_ready = !w_full;
  assign rob.issue_tag   = r_tail;
  assign rob.full        = w_full;
  assign rob.empty       = (r_count == '0);
  assign rob.count       = r_count;
  assign rob.head_valid  = w_head_valid;
  assign rob.head_tag    = r_head;
  assign rob.head_instr  = r_instr[r_head];
  assign rob.head_dest   = w_head_dest;
  assign rob.head_value  = r_value[r_head];
  assign rob.src_busy    = r_busy[rob.src_reg];
  assign rob.src_tag     = r_rtag[rob.src_reg];

  always_comb begin
    w_count_d = r_count;
    if (w_alloc && !w_commit) begin
      w_count_d = r_count + 1'b1;
    end else if (!w_alloc && w_commit) begin
      w_count_d = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
      if (w_alloc) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_commit) begin
        r_head <= r_head + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc <= '0;
      r_ready <= '0;
      for (int i = 0; i < int'(ROB_DEPTH); i++) begin
        r_instr[i] <= '0;
        r_dest[i]  <= '0;
        r_value[i] <= '0;
      end
    end else begin
      if (w_commit) begin
        r_alloc[r_head] <= 1'b0;
        r_ready[r_head] <= 1'b0;
      end
      if (w_cdb) begin
        r_ready[rob.cdb_tag] <= 1'b1;
        r_value[rob.cdb_tag] <= rob.cdb_value;
      end
      if (w_alloc) begin
        r_alloc[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_instr[r_tail] <= rob.issue_instr;
        r_dest[r_tail]  <= rob.issue_dest;
      end
    end
  end

  // Allocation is written last so it overrides a same-register commit release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      for (int i = 0; i < int'(NumRegs); i++) begin
        r_rtag[i] <= '0;
      end
    end else begin
      if (w_rename_clr) begin
        r_busy[w_head_dest] <= 1'b0;
      end
      if (w_alloc) begin
        r_busy[rob.issue_dest] <= 1'b1;
        r_rtag[rob.issue_dest] <= r_tail;
      end
    end
  end
endmodule

// File: tb/tb_rob_issue_alloc.sv
// Directed, table-driven bench for rob_issue_alloc with hand-written wrap,
// full+commit and mid-stream reset sequences.
module tb_rob_issue_alloc;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rob_issue_alloc_if rob_if ();

  rob_issue_alloc dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rob  (rob_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] instr;
    logic [2:0]  dest;
    logic [2:0]  src;
    logic        cv;
    logic [1:0]  ctag;
    logic [15:0] cval;
    logic        ack;
    logic [2:0]  e_cnt;
    logic [1:0]  e_itag;
    logic [1:0]  e_htag;
    logic        e_hv;
    logic [15:0] e_hval;
    logic [15:0] e_hins;
    logic        e_busy;
    logic [1:0]  e_stag;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] instr, input logic [2:0] dest,
                       input logic [2:0] src, input logic cv, input logic [1:0] ctag,
                       input logic [15:0] cval, input logic ack);
    rob_if.issue_valid = iv;
    rob_if.issue_instr = instr;
    rob_if.issue_dest  = dest;
    rob_if.src_reg     = src;
    rob_if.cdb_valid   = cv;
    rob_if.cdb_tag     = ctag;
    rob_if.cdb_value   = cval;
    rob_if.commit_ack  = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string nm, input logic [2:0] cnt, input logic [1:0] itag,
                             input logic [1:0] htag, input logic hv, input logic [15:0] hval,
                             input logic [15:0] hins, input logic busy, input logic [1:0] stag);
    chk({nm, " count"}, 32'(rob_if.count), 32'(cnt));
    chk({nm, " full"}, 32'(rob_if.full), 32'(cnt == 3'd4));
    chk({nm, " empty"}, 32'(rob_if.empty), 32'(cnt == 3'd0));
    chk({nm, " issue_ready"}, 32'(rob_if.issue_ready), 32'(cnt != 3'd4));
    chk({nm, " issue_tag"}, 32'(rob_if.issue_tag), 32'(itag));
    chk({nm, " head_tag"}, 32'(rob_if.head_tag), 32'(htag));
    chk({nm, " head_valid"}, 32'(rob_if.head_valid), 32'(hv));
    chk({nm, " src_busy"}, 32'(rob_if.src_busy), 32'(busy));
    if (hv) begin
      chk({nm, " head_value"}, 32'(rob_if.head_value), 32'(hval));
      chk({nm, " head_instr"}, 32'(rob_if.head_instr), 32'(hins));
    end
    if (busy) chk({nm, " src_tag"}, 32'(rob_if.src_tag), 32'(stag));
  endtask

  initial begin
    logic [1:0]  h;
    logic [1:0]  t;
    logic [15:0] hins;
    total = 0;
    bad   = 0;

    // iv instr dest src cv ctag cval ack | cnt itag htag hv hval hins busy stag
    vecs[0]  = '{1'b1, 16'h1A01, 3'd1, 3'd1, 1'b0, 2'd0, 16'h0000, 1'b0,
                 3'd1, 2'd1, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0};
    vecs[1]  = '{1'b1, 16'h1A02, 3'd2, 3'd2, 1'b0, 2'd0, 16'h0000, 1'b0,
                 3'd2, 2'd2, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd1};
    vecs[2]  = '{1'b1, 16'h1A03, 3'd3, 3'd3, 1'b0, 2'd0, 16'h0000, 1'b0,
                 3'd3, 2'd3, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd2};
    vecs[3]  = '{1'b1, 16'h1A04, 3'd4, 3'd4, 1'b0, 2'd0, 16'h0000, 1'b0,
                 3'd4, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd3};
    vecs[4]  = '{1'b1, 16'h1A05, 3'd6, 3'd6, 1'b0, 2'd0, 16'h0000, 1'b0,
                 3'd4, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 16'h0000, 3'd0, 3'd1, 1'b1, 2'd2, 16'h00BB, 1'b0,
                 3'd4, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0};
    vecs[6]  = '{1'b0, 16'h0000, 3'd0, 3'd1, 1'b1, 2'd0, 16'h00AA, 1'b0,
                 3'd4, 2'd0, 2'd0, 1'b1, 16'h00AA, 16'h1A01, 1'b1, 2'd0};
    vecs[7]  = '{1'b0, 16'h0000, 3'd0, 3'd1, 1'b0, 2'd0, 16'h0000, 1'b1,
                 3'd3, 2'd0, 2'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0};
    vecs[8]  = '{1'b0, 16'h0000, 3'd0, 3'd1, 1'b0, 2'd0, 16'h0000, 1'b1,
                 3'd3, 2'd0, 2'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0};
    vecs[9]  = '{1'b0, 16'h0000, 3'd0, 3'd2, 1'b1, 2'd1, 16'h0011, 1'b0,
                 3'd3, 2'd0, 2'd1, 1'b1, 16'h0011, 16'h1A02, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 16'h0000, 3'd0, 3'd2, 1'b1, 2'd2, 16'h00CC, 1'b1,
                 3'd2, 2'd0, 2'd2, 1'b1, 16'h00BB, 16'h1A03, 1'b0, 2'd0};
    vecs[11] = '{1'b0, 16'h0000, 3'd0, 3'd3, 1'b1, 2'd1, 16'h0077, 1'b0,
                 3'd2, 2'd0, 2'd2, 1'b1, 16'h00BB, 16'h1A03, 1'b1, 2'd2};
    vecs[12] = '{1'b0, 16'h0000, 3'd0, 3'd3, 1'b0, 2'd0, 16'h0000, 1'b1,
                 3'd1, 2'd0, 2'd3, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 16'h0000, 3'd0, 3'd4, 1'b1, 2'd3, 16'h0044, 1'b0,
                 3'd1, 2'd0, 2'd3, 1'b1, 16'h0044, 16'h1A04, 1'b1, 2'd3};
    vecs[14] = '{1'b0, 16'h0000, 3'd0, 3'd4, 1'b0, 2'd0, 16'h0000, 1'b1,
                 3'd0, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0};
    vecs[15] = '{1'b1, 16'h2B01, 3'd5, 3'd5, 1'b0, 2'd0, 16'h0000, 1'b0,
                 3'd1, 2'd1, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0};
    vecs[16] = '{1'b1, 16'h2B02, 3'd5, 3'd5, 1'b0, 2'd0, 16'h0000, 1'b0,
                 3'd2, 2'd2, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd1};
    vecs[17] = '{1'b0, 16'h0000, 3'd0, 3'd5, 1'b1, 2'd0, 16'h0101, 1'b0,
                 3'd2, 2'd2, 2'd0, 1'b1, 16'h0101, 16'h2B01, 1'b1, 2'd1};
    vecs[18] = '{1'b0, 16'h0000, 3'd0, 3'd5, 1'b0, 2'd0, 16'h0000, 1'b1,
                 3'd1, 2'd2, 2'd1, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd1};
    vecs[19] = '{1'b0, 16'h0000, 3'd0, 3'd5, 1'b1, 2'd1, 16'h0202, 1'b0,
                 3'd1, 2'd2, 2'd1, 1'b1, 16'h0202, 16'h2B02, 1'b1, 2'd1};
    vecs[20] = '{1'b0, 16'h0000, 3'd0, 3'd5, 1'b0, 2'd0, 16'h0000, 1'b1,
                 3'd0, 2'd2, 2'd2, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0};

    rst_n = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 2'd0, 16'h0, 1'b0);
    #12;
    check_state("reset", 3'd0, 2'd0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].iv, vecs[i].instr, vecs[i].dest, vecs[i].src, vecs[i].cv, vecs[i].ctag,
            vecs[i].cval, vecs[i].ack);
      step();
      check_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_itag, vecs[i].e_htag,
                  vecs[i].e_hv, vecs[i].e_hval, vecs[i].e_hins, vecs[i].e_busy,
                  vecs[i].e_stag);
    end

    // Wrap: head=tail=2, one live entry, then issue+commit pairs to r7.
    drive(1'b1, 16'h3CFF, 3'd7, 3'd7, 1'b0, 2'd0, 16'h0, 1'b0);
    step();
    check_state("wrap_seed", 3'd1, 2'd3, 2'd2, 1'b0, 16'h0, 16'h0, 1'b1, 2'd2);
    for (int k = 0; k < 6; k++) begin
      h    = 2'd2 + k[1:0];
      t    = 2'd3 + k[1:0];
      hins = (k == 0) ? 16'h3CFF : 16'(16'h3C00 + k - 1);
      // CDB to the not-yet-ready head alongside commit_ack: no commit this cycle.
      drive(1'b0, 16'h0, 3'd0, 3'd7, 1'b1, h, 16'(16'h0500 + k), 1'b1);
      step();
      check_state($sformatf("wrap%0d_cdb", k), 3'd1, t, h, 1'b1, 16'(16'h0500 + k), hins,
                  1'b1, h);
      drive(1'b1, 16'(16'h3C00 + k), 3'd7, 3'd7, 1'b0, 2'd0, 16'h0, 1'b1);
      step();
      check_state($sformatf("wrap%0d_pair", k), 3'd1, t + 2'd1, t, 1'b0, 16'h0, 16'h0,
                  1'b1, t);
    end

    // Refill to full behind the pending head (tag0).
    for (int j = 1; j < 4; j++) begin
      drive(1'b1, 16'(16'h4D00 + j), 3'(j), 3'(j), 1'b0, 2'd0, 16'h0, 1'b0);
      step();
      check_state($sformatf("refill%0d", j), 3'(j + 1), 2'(j + 1), 2'd0, 1'b0, 16'h0,
                  16'h0, 1'b1, 2'(j));
    end
    drive(1'b0, 16'h0, 3'd0, 3'd7, 1'b1, 2'd0, 16'h0600, 1'b0);
    step();
    check_state("full_cdb", 3'd4, 2'd0, 2'd0, 1'b1, 16'h0600, 16'h3C05, 1'b1, 2'd0);

    // Full + commit: the same-cycle issue is still refused.
    drive(1'b1, 16'h4D04, 3'd6, 3'd6, 1'b0, 2'd0, 16'h0, 1'b1);
    #1;
    chk("full_commit issue_ready_before", 32'(rob_if.issue_ready), 32'd0);
    step();
    check_state("full_commit", 3'd3, 2'd0, 2'd1, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0);

    // Mid-stream reset with three live entries.
    drive(1'b0, 16'h0, 3'd0, 3'd1, 1'b0, 2'd0, 16'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #2;
    check_state("midreset", 3'd0, 2'd0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
    #3;
    rst_n = 1'b1;
    step();
    check_state("post_reset", 3'd0, 2'd0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
    for (int r = 0; r < 8; r++) begin
      rob_if.src_reg = 3'(r);
      #1;
      chk($sformatf("post_reset src_busy r%0d", r), 32'(rob_if.src_busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rob_issue_alloc.md
Name: rob_issue_alloc

Overview:
- Allocation/writeback side of the reorder buffer: the producer of the entries that the commit stage retires.
- Allocates ROB entries at the tail for issued instructions and records each entry's destination register.
- Maintains the register rename table (busy + tag per architectural register).
- Captures CDB results into entries and presents the head entry, with a ready flag, to the commit stage, which pops it with commit_ack.

Parameters:
- ROB_DEPTH, 4: number of ROB entries; power of two.
- TAG_W, 2: log2(ROB_DEPTH); ROB tag width.
- DATA_W, 16: result value width.
- INSTR_W, 16: instruction word width.
- REG_ADDR_W, 3: architectural register index width (2**REG_ADDR_W registers).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issue stage requests an entry this cycle.
- issue_ready  out  1  entry available; equals !full.
- issue_instr  in  INSTR_W  instruction word to record.
- issue_dest  in  REG_ADDR_W  destination architectural register.
- issue_tag  out  TAG_W  tag the entry receives if allocated this cycle (tail pointer).
- src_reg  in  REG_ADDR_W  rename lookup address.
- src_busy  out  1  combinational: src_reg has a pending producer.
- src_tag  out  TAG_W  combinational: producer tag of src_reg.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  tag of broadcast result.
- cdb_value  in  DATA_W  broadcast result value.
- head_valid  out  1  head entry allocated and its value captured.
- head_tag  out  TAG_W  head pointer.
- head_instr  out  INSTR_W  head instruction word.
- head_dest  out  REG_ADDR_W  head destination register.
- head_value  out  DATA_W  head result value.
- commit_ack  in  1  commit stage retires the head this cycle.
- count  out  TAG_W+1  occupied entries, 0..ROB_DEPTH.
- empty  out  1  count==0.
- full  out  1  count==ROB_DEPTH.

Behaviour:
- Reset (async, rst_n low):
  - head = tail = 0, count = 0.
  - All entry alloc/ready bits = 0; all rename busy = 0, rename tags = 0.
  - Outputs: issue_ready=1, empty=1, full=0, head_valid=0, issue_tag=0, src_busy=0.
  - Data fields: head_instr/head_dest/head_value and src_tag are don't-care until written, then 0 after reset.
  - Reset mid-operation discards all entries; no partial state survives.
- Per-entry state: alloc, ready, instr, dest, value.
- Allocate (issue_valid && issue_ready):
  - At the edge, write entry[tail] = {alloc=1, ready=0, instr, dest, value unchanged}.
  - tail += 1, wrapping modulo ROB_DEPTH.
  - Set rename[issue_dest] = {busy=1, tag=tail}.
  - issue_valid while full is ignored; no state change.
- CDB capture:
  - If cdb_valid && entry[cdb_tag].alloc && !entry[cdb_tag].ready: value <= cdb_value, ready <= 1.
  - A broadcast to an unallocated or already-ready tag is ignored.
  - A broadcast never targets the entry being allocated in the same cycle; if it does, the allocation wins.
- Head outputs: combinational from entry[head]; head_valid = alloc && ready. Latency from CDB to head_valid is 1 cycle.
- Commit (commit_ack && head_valid):
  - Clear entry[head].alloc/ready; head += 1 with wrap.
  - If rename[head_dest].busy && rename[head_dest].tag==head: clear busy.
  - commit_ack while !head_valid is ignored.
- Simultaneous events:
  - Allocate + commit in one cycle: count unchanged; both pointers advance.
  - Allocate + commit with the same dest register: the allocation's rename write wins; busy stays 1 with the new tag.
  - CDB to the head entry + commit_ack in the same cycle: no commit (head_valid still 0 that cycle).
  - Full + commit: issue_ready stays 0 for that cycle, because issue_ready is derived from registered count; it rises the next cycle.
- count updates: +1 on allocate only, -1 on commit only, otherwise unchanged. It never exceeds ROB_DEPTH or underflows.
- Rename lookup is combinational on current state and does not bypass same-cycle allocation.

Test Plan:
- Reset: hold rst_n=0 mid-stream with 3 entries live -> count=0, empty=1, issue_ready=1, head_valid=0, all src_busy=0 after release.
- Fill: issue 4 instrs (0x1A01..0x1A04, dest r1..r4) -> issue_tag 0,1,2,3; full=1, issue_ready=0; 5th issue_valid ignored, count stays 4.
- Out-of-order writeback: CDB tag2=0x00BB then tag0=0x00AA -> head_valid=1 only after tag0, head_value=0x00AA; commit_ack retires tag0, then head_valid=0 until tag1 broadcasts.
- Rename: issue tag0 and tag1 both to r5 -> src_reg=5 gives busy=1, tag=1; committing tag0 leaves busy=1; committing tag1 clears busy.
- Wrap: run 6 allocate/commit pairs -> tags wrap 3->0; simultaneous issue+commit keeps count constant, with no lost or duplicated entries.
- Stale CDB: broadcast to an unallocated tag, and a second broadcast to a ready tag with a different value -> no state change, original value retained.
